// File: rtl/dco_tune_pkg.sv
// Shared types, bank constants and arithmetic helpers for the DCO tuning controller.
package dco_tune_pkg;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_PWRUP = 3'd1,
    ST_PVT   = 3'd2,
    ST_ACQ   = 3'd3,
    ST_TRK   = 3'd4
  } mode_t;

  localparam int N_L = 25;
  localparam int N_M = 256;
  localparam int N_S = 256;
  localparam int W_L = 5;
  localparam int W_M = 16;

  typedef struct packed {
    logic [7:0] code;
    logic       clip;
  } sat_res_t;

  // Externally visible mode: PWRUP reports as OFF.
  function automatic logic [1:0] mode_out(input mode_t m);
    case (m)
      ST_PVT:  return 2'd1;
      ST_ACQ:  return 2'd2;
      ST_TRK:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Magnitude of a sign-extended delta; the most negative value maps to its
  // true magnitude because the result is read as unsigned.
  function automatic logic [15:0] abs16(input logic signed [15:0] d);
    if (d[15]) return ~d + 16'd1;
    else       return d;
  endfunction

  // Add a signed delta to a bank code and clip to [0, max_code].
  function automatic sat_res_t sat_add(input logic [7:0] code,
                                       input logic signed [15:0] delta,
                                       input logic [7:0] max_code);
    logic signed [17:0] sum;
    sat_res_t           res;
    sum = $signed({10'd0, code}) + $signed({{2{delta[15]}}, delta});
    if (sum < 18'sd0) begin
      res.code = 8'd0;
      res.clip = 1'b1;
    end else if (sum > $signed({10'd0, max_code})) begin
      res.code = max_code;
      res.clip = 1'b1;
    end else begin
      res.code = sum[7:0];
      res.clip = 1'b0;
    end
    return res;
  endfunction

  // One column of the row/column unit matrix: {rall[i], row[i], col[i]}.
  // Code zero selects nothing, including the row line.
  function automatic logic [2:0] tcode_bits(input int unsigned code,
                                            input int unsigned w,
                                            input int unsigned i);
    int unsigned q;
    int unsigned r;
    q = code / w;
    r = code % w;
    return {(i < q), (i == q) && (code != 0), (i < r)};
  endfunction

  // Full select pattern {rall, row, col}, 16 bits per field, for reset constants.
  function automatic logic [47:0] tcode_vec(input int unsigned code, input int unsigned w);
    logic [47:0] v;
    logic [2:0]  b;
    v = '0;
    for (int unsigned i = 0; i < w && i < 16; i++) begin
      b = tcode_bits(code, w, i);
      v[32 + i] = b[2];
      v[16 + i] = b[1];
      v[i]      = b[0];
    end
    return v;
  endfunction

endpackage

// File: rtl/dco_tune_ctrl_if.sv
// Loop-filter to controller tuning-word strobe and increment.
interface dco_tune_ctrl_if #(parameter int DW = 8);
  logic                 otw_vld;
  logic signed [DW-1:0] otw_delta;

  modport master (output otw_vld, output otw_delta);
  modport slave  (input  otw_vld, input  otw_delta);
endinterface

// File: rtl/dco_tune_ctrl_tcode_enc.sv
// Combinational code to rall/row/col select encoder for one W x W bank.
module tcode_enc
  import dco_tune_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [$clog2(W*W+1)-1:0] code,
  output logic [W-1:0]             rall,
  output logic [W-1:0]             row,
  output logic [W-1:0]             col
);

  // Build each select line from the quotient/remainder of the code.
  always_comb begin
    rall = '0;
    row  = '0;
    col  = '0;
    for (int i = 0; i < W; i++) begin
      {rall[i], row[i], col[i]} = tcode_bits(32'(code), W, i);
    end
  end

endmodule

// File: rtl/dco_tune_ctrl.sv
// DCO tuning controller: mode sequencing, bank code steering and select-bus drive.
module dco_tune_ctrl
  import dco_tune_pkg::*;
#(
  parameter int DW         = 8,
  parameter int L_INIT     = 12,
  parameter int M_INIT     = 128,
  parameter int S_INIT     = 128,
  parameter int SETTLE_CYC = 16,
  parameter int LOCK_THR   = 1,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_THR = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [1:0]      osc_gain_cfg,
  dco_tune_ctrl_if.slave  lf,
  output logic            pd,
  output logic [1:0]      osc_gain,
  output logic [W_L-1:0]  c_l_rall, c_l_row, c_l_col,
  output logic [W_M-1:0]  c_m_rall, c_m_row, c_m_col,
  output logic [W_M-1:0]  c_s_rall, c_s_row, c_s_col,
  output logic [1:0]      mode,
  output logic            lock,
  output logic            sat
);

  localparam int SCW = $clog2(SETTLE_CYC + 1);
  localparam int LCW = $clog2(LOCK_CNT + 1);
  localparam logic [47:0] L_RST = tcode_vec(L_INIT, W_L);
  localparam logic [47:0] M_RST = tcode_vec(M_INIT, W_M);
  localparam logic [47:0] S_RST = tcode_vec(S_INIT, W_M);

  mode_t              state_r, nxt_state_s;
  logic [SCW-1:0]     settle_r, nxt_settle_s;
  logic [LCW-1:0]     lock_cnt_r, nxt_lock_cnt_s;
  logic [4:0]         code_l_r, nxt_l_s;
  logic [7:0]         code_m_r, code_s_r, nxt_m_s, nxt_s_s;
  logic               nxt_sat_s;
  logic signed [DW-1:0] otw_delta_s;
  logic signed [15:0] delta_s;
  logic [15:0]        abs_s;
  logic               in_thr_s, unlock_s;
  logic [7:0]         act_code_s, act_max_s;
  sat_res_t           sum_s;
  logic [W_L-1:0]     enc_l_rall_s, enc_l_row_s, enc_l_col_s;
  logic [W_M-1:0]     enc_m_rall_s, enc_m_row_s, enc_m_col_s;
  logic [W_M-1:0]     enc_s_rall_s, enc_s_row_s, enc_s_col_s;

  assign otw_delta_s = lf.otw_delta;
  assign delta_s     = 16'(otw_delta_s);
  assign abs_s       = abs16(delta_s);
  assign in_thr_s    = abs_s <= 16'(LOCK_THR);
  assign unlock_s    = abs_s > 16'(UNLOCK_THR);
  assign sum_s       = sat_add(act_code_s, delta_s, act_max_s);

  // Route the bank owned by the current mode into the shared saturating adder.
  always_comb begin
    act_code_s = 8'd0;
    act_max_s  = 8'd0;
    case (state_r)
      ST_PVT:  begin act_code_s = {3'd0, code_l_r}; act_max_s = 8'(N_L);     end
      ST_ACQ:  begin act_code_s = code_m_r;         act_max_s = 8'(N_M - 1); end
      ST_TRK:  begin act_code_s = code_s_r;         act_max_s = 8'(N_S - 1); end
      default: begin act_code_s = 8'd0;             act_max_s = 8'd0;        end
    endcase
  end

  // Next mode, settle/lock counters, bank codes and sticky saturation flag.
  always_comb begin
    nxt_state_s    = state_r;
    nxt_settle_s   = settle_r;
    nxt_lock_cnt_s = lock_cnt_r;
    nxt_l_s        = code_l_r;
    nxt_m_s        = code_m_r;
    nxt_s_s        = code_s_r;
    nxt_sat_s      = sat;
    if (!en) begin
      nxt_state_s    = ST_OFF;
      nxt_settle_s   = '0;
      nxt_lock_cnt_s = '0;
      nxt_l_s        = 5'(L_INIT);
      nxt_m_s        = 8'(M_INIT);
      nxt_s_s        = 8'(S_INIT);
      nxt_sat_s      = 1'b0;
    end else begin
      case (state_r)
        ST_OFF: begin
          nxt_state_s  = ST_PWRUP;
          nxt_settle_s = SCW'(SETTLE_CYC - 1);
        end
        ST_PWRUP: begin
          if (settle_r == '0) nxt_state_s = ST_PVT;
          else                nxt_settle_s = settle_r - 1'b1;
        end
        ST_PVT, ST_ACQ, ST_TRK: begin
          if (lf.otw_vld) begin
            case (state_r)
              ST_PVT:  nxt_l_s = sum_s.code[4:0];
              ST_ACQ:  nxt_m_s = sum_s.code;
              default: nxt_s_s = sum_s.code;
            endcase
            nxt_sat_s = sat | sum_s.clip;
            if (in_thr_s) begin
              if (state_r != ST_TRK && lock_cnt_r == LCW'(LOCK_CNT - 1)) begin
                nxt_state_s    = (state_r == ST_PVT) ? ST_ACQ : ST_TRK;
                nxt_lock_cnt_s = '0;
              end else if (lock_cnt_r != LCW'(LOCK_CNT)) begin
                nxt_lock_cnt_s = lock_cnt_r + 1'b1;
              end else begin
                nxt_lock_cnt_s = lock_cnt_r;
              end
            end else begin
              nxt_lock_cnt_s = '0;
              if (state_r == ST_TRK && unlock_s) nxt_state_s = ST_ACQ;
              else                               nxt_state_s = state_r;
            end
          end else begin
            nxt_state_s = state_r;
          end
        end
        default: nxt_state_s = ST_OFF;
      endcase
    end
  end

  tcode_enc #(.W(W_L)) u_enc_l (.code(nxt_l_s),         .rall(enc_l_rall_s), .row(enc_l_row_s), .col(enc_l_col_s));
  tcode_enc #(.W(W_M)) u_enc_m (.code({1'b0, nxt_m_s}), .rall(enc_m_rall_s), .row(enc_m_row_s), .col(enc_m_col_s));
  tcode_enc #(.W(W_M)) u_enc_s (.code({1'b0, nxt_s_s}), .rall(enc_s_rall_s), .row(enc_s_row_s), .col(enc_s_col_s));

  // State, codes and every output register; select buses move with their codes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_OFF;
      settle_r   <= '0;
      lock_cnt_r <= '0;
      code_l_r   <= 5'(L_INIT);
      code_m_r   <= 8'(M_INIT);
      code_s_r   <= 8'(S_INIT);
      sat        <= 1'b0;
      pd         <= 1'b1;
      osc_gain   <= 2'd0;
      mode       <= 2'd0;
      lock       <= 1'b0;
      c_l_rall   <= L_RST[32 +: W_L];
      c_l_row    <= L_RST[16 +: W_L];
      c_l_col    <= L_RST[0  +: W_L];
      c_m_rall   <= M_RST[47:32];
      c_m_row    <= M_RST[31:16];
      c_m_col    <= M_RST[15:0];
      c_s_rall   <= S_RST[47:32];
      c_s_row    <= S_RST[31:16];
      c_s_col    <= S_RST[15:0];
    end else begin
      state_r    <= nxt_state_s;
      settle_r   <= nxt_settle_s;
      lock_cnt_r <= nxt_lock_cnt_s;
      code_l_r   <= nxt_l_s;
      code_m_r   <= nxt_m_s;
      code_s_r   <= nxt_s_s;
      sat        <= nxt_sat_s;
      pd         <= (nxt_state_s == ST_OFF);
      osc_gain   <= osc_gain_cfg;
      mode       <= mode_out(nxt_state_s);
      lock       <= (nxt_state_s == ST_TRK);
      c_l_rall   <= enc_l_rall_s;
      c_l_row    <= enc_l_row_s;
      c_l_col    <= enc_l_col_s;
      c_m_rall   <= enc_m_rall_s;
      c_m_row    <= enc_m_row_s;
      c_m_col    <= enc_m_col_s;
      c_s_rall   <= enc_s_rall_s;
      c_s_row    <= enc_s_row_s;
      c_s_col    <= enc_s_col_s;
    end
  end

endmodule

// File: tb/tb_dco_tune_ctrl.sv
// Directed self-checking bench for dco_tune_ctrl.
module tb_dco_tune_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  osc_gain_cfg;
  logic        pd;
  logic [1:0]  osc_gain;
  logic [4:0]  c_l_rall, c_l_row, c_l_col;
  logic [15:0] c_m_rall, c_m_row, c_m_col;
  logic [15:0] c_s_rall, c_s_row, c_s_col;
  logic [1:0]  mode;
  logic        lock;
  logic        sat;
  int          checks = 0;
  int          errors = 0;

  localparam logic [14:0] L12 = 15'b00011_00100_00011;
  localparam logic [14:0] L19 = 15'b00111_01000_01111;
  localparam logic [14:0] L25 = 15'b11111_00000_00000;
  localparam logic [14:0] L16 = 15'b00111_01000_00001;
  localparam logic [47:0] B128 = 48'h00FF_0100_0000;
  localparam logic [47:0] B144 = 48'h01FF_0200_0000;
  localparam logic [47:0] B28  = 48'h0001_0002_0FFF;
  localparam logic [47:0] B36  = 48'h0003_0004_000F;

  dco_tune_ctrl_if #(.DW(8)) lf ();

  dco_tune_ctrl dut (
    .clk(clk), .rst_n(rst_n), .en(en), .osc_gain_cfg(osc_gain_cfg), .lf(lf),
    .pd(pd), .osc_gain(osc_gain),
    .c_l_rall(c_l_rall), .c_l_row(c_l_row), .c_l_col(c_l_col),
    .c_m_rall(c_m_rall), .c_m_row(c_m_row), .c_m_col(c_m_col),
    .c_s_rall(c_s_rall), .c_s_row(c_s_row), .c_s_col(c_s_col),
    .mode(mode), .lock(lock), .sat(sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic signed [7:0] d);
    lf.otw_vld   = vld;
    lf.otw_delta = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; osc_gain_cfg = 2'b10; drive(1'b0, 8'sd0);
    repeat (3) step();
    checks++; if (osc_gain !== 2'd0) begin errors++; $display("FAIL reset_osc_gain got %0d expected 0", osc_gain); end
    rst_n = 1'b1;
    step();
    checks++; if (pd !== 1'b1) begin errors++; $display("FAIL reset_pd got %b expected 1", pd); end
    checks++; if ({mode, lock, sat} !== 4'b0000) begin errors++; $display("FAIL reset_mode_lock_sat got %b expected 0000", {mode, lock, sat}); end
    checks++; if (osc_gain !== 2'd2) begin errors++; $display("FAIL gain_copy got %0d expected 2", osc_gain); end
    checks++; if ({c_l_rall, c_l_row, c_l_col} !== L12) begin errors++; $display("FAIL reset_l_bus got %b expected %b", {c_l_rall, c_l_row, c_l_col}, L12); end
    checks++; if ({c_m_rall, c_m_row, c_m_col} !== B128) begin errors++; $display("FAIL reset_m_bus got %h expected %h", {c_m_rall, c_m_row, c_m_col}, B128); end
    checks++; if ({c_s_rall, c_s_row, c_s_col} !== B128) begin errors++; $display("FAIL reset_s_bus got %h expected %h", {c_s_rall, c_s_row, c_s_col}, B128); end
  endtask

  task automatic test_pwrup();
    en = 1'b1;
    step();
    checks++; if ({pd, mode} !== 3'b000) begin errors++; $display("FAIL pwrup_pd_mode got %b expected 000", {pd, mode}); end
    drive(1'b1, 8'sd5);
    for (int i = 1; i <= 15; i++) begin
      step();
      checks++; if (mode !== 2'd0) begin errors++; $display("FAIL pwrup_hold_%0d got mode %0d expected 0", i, mode); end
    end
    drive(1'b0, 8'sd0);
    step();
    checks++; if (mode !== 2'd1) begin errors++; $display("FAIL pvt_entry got mode %0d expected 1", mode); end
    checks++; if ({c_l_rall, c_l_row, c_l_col} !== L12) begin errors++; $display("FAIL pwrup_l_frozen got %b expected %b", {c_l_rall, c_l_row, c_l_col}, L12); end
    checks++; if ({c_m_rall, c_m_row, c_m_col, c_s_rall, c_s_row, c_s_col} !== {B128, B128}) begin errors++; $display("FAIL pwrup_ms_frozen got %h expected %h", {c_m_rall, c_m_row, c_m_col, c_s_rall, c_s_row, c_s_col}, {B128, B128}); end
  endtask

  task automatic test_pvt_clip();
    drive(1'b1, 8'sd7);
    step();
    checks++; if ({c_l_rall, c_l_row, c_l_col, sat} !== {L19, 1'b0}) begin errors++; $display("FAIL pvt_l19 got %b expected %b", {c_l_rall, c_l_row, c_l_col, sat}, {L19, 1'b0}); end
    step();
    checks++; if ({c_l_rall, c_l_row, c_l_col, sat} !== {L25, 1'b1}) begin errors++; $display("FAIL pvt_clip_hi got %b expected %b", {c_l_rall, c_l_row, c_l_col, sat}, {L25, 1'b1}); end
    drive(1'b1, -8'sd30);
    step();
    checks++; if ({c_l_rall, c_l_row, c_l_col} !== 15'd0) begin errors++; $display("FAIL pvt_clip_lo got %b expected 0", {c_l_rall, c_l_row, c_l_col}); end
    drive(1'b0, 8'sd0);
    step();
    checks++; if ({sat, mode} !== 3'b101) begin errors++; $display("FAIL pvt_sat_sticky got %b expected 101", {sat, mode}); end
  endtask

  task automatic test_mode_advance();
    drive(1'b1, 8'sd12);
    step();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 8'sd1);
      step();
      checks++; if (mode !== ((i == 4) ? 2'd2 : 2'd1)) begin errors++; $display("FAIL pvt_lock_%0d got mode %0d", i, mode); end
    end
    checks++; if ({c_l_rall, c_l_row, c_l_col} !== L16) begin errors++; $display("FAIL pvt_l16 got %b expected %b", {c_l_rall, c_l_row, c_l_col}, L16); end
    drive(1'b1, 8'sd0);  step();
    drive(1'b1, -8'sd1); step();
    drive(1'b1, 8'sd1);  step();
    checks++; if ({mode, lock} !== 3'b100) begin errors++; $display("FAIL acq_before_lock got %b expected 100", {mode, lock}); end
    drive(1'b1, 8'sd0);  step();
    drive(1'b0, 8'sd0);
    checks++; if ({mode, lock} !== 3'b111) begin errors++; $display("FAIL acq_to_trk got %b expected 111", {mode, lock}); end
    checks++; if ({c_m_rall, c_m_row, c_m_col} !== B128) begin errors++; $display("FAIL acq_m128 got %h expected %h", {c_m_rall, c_m_row, c_m_col}, B128); end
    checks++; if ({c_l_rall, c_l_row, c_l_col} !== L16) begin errors++; $display("FAIL acq_l_frozen got %b expected %b", {c_l_rall, c_l_row, c_l_col}, L16); end
  endtask

  task automatic test_trk_fallback();
    drive(1'b1, -8'sd100);
    step();
    checks++; if ({mode, lock} !== 3'b100) begin errors++; $display("FAIL trk_unlock got %b expected 100", {mode, lock}); end
    checks++; if ({c_s_rall, c_s_row, c_s_col} !== B28) begin errors++; $display("FAIL trk_s28 got %h expected %h", {c_s_rall, c_s_row, c_s_col}, B28); end
    drive(1'b1, 8'sd1); repeat (3) step();
    drive(1'b1, 8'sd9); step();
    drive(1'b1, 8'sd1); repeat (3) step();
    checks++; if (mode !== 2'd2) begin errors++; $display("FAIL acq_restart got mode %0d expected 2", mode); end
    step();
    checks++; if ({mode, lock} !== 3'b111) begin errors++; $display("FAIL acq_relock got %b expected 111", {mode, lock}); end
    checks++; if ({c_m_rall, c_m_row, c_m_col} !== B144) begin errors++; $display("FAIL acq_m144 got %h expected %h", {c_m_rall, c_m_row, c_m_col}, B144); end
    drive(1'b1, 8'sd8);
    step();
    checks++; if ({mode, c_s_rall, c_s_row, c_s_col} !== {2'd3, B36}) begin errors++; $display("FAIL trk_at_unlock_thr got %h expected %h", {mode, c_s_rall, c_s_row, c_s_col}, {2'd3, B36}); end
    drive(1'b1, 8'sh80);
    step();
    checks++; if ({mode, c_s_rall, c_s_row, c_s_col} !== {2'd2, 48'd0}) begin errors++; $display("FAIL trk_min_delta got %h expected %h", {mode, c_s_rall, c_s_row, c_s_col}, {2'd2, 48'd0}); end
    drive(1'b1, 8'sd0); repeat (4) step();
    checks++; if ({mode, sat} !== 3'b111) begin errors++; $display("FAIL trk_again got %b expected 111", {mode, sat}); end
  endtask

  task automatic test_disable();
    en = 1'b0; drive(1'b1, 8'sd5);
    step();
    drive(1'b0, 8'sd0);
    checks++; if ({pd, mode, lock, sat} !== 5'b10000) begin errors++; $display("FAIL dis_flags got %b expected 10000", {pd, mode, lock, sat}); end
    checks++; if ({c_l_rall, c_l_row, c_l_col} !== L12) begin errors++; $display("FAIL dis_l got %b expected %b", {c_l_rall, c_l_row, c_l_col}, L12); end
    checks++; if ({c_m_rall, c_m_row, c_m_col, c_s_rall, c_s_row, c_s_col} !== {B128, B128}) begin errors++; $display("FAIL dis_ms got %h expected %h", {c_m_rall, c_m_row, c_m_col, c_s_rall, c_s_row, c_s_col}, {B128, B128}); end
  endtask

  task automatic test_async_reset();
    en = 1'b1;
    step();
    checks++; if (pd !== 1'b0) begin errors++; $display("FAIL ar_pwrup_pd got %b expected 0", pd); end
    rst_n = 1'b0;
    #2;
    checks++; if ({pd, osc_gain} !== 3'b100) begin errors++; $display("FAIL ar_immediate got %b expected 100", {pd, osc_gain}); end
    en = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_pwrup();
    test_pvt_clip();
    test_mode_advance();
    test_trk_fallback();
    test_disable();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
